// File: rtl/shift_feeder.sv
// Request/response feeder around an external combinational shifter; one result per
// request, or a sweep of in_amt..7 when built with SHIFT_SWEEP_EN defined.
module shift_feeder (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic [2:0] in_amt,
   input  logic       in_sweep,
   output logic [7:0] sh_in,
   output logic [2:0] sh_amt,
   input  logic [7:0] sh_q,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [2:0] out_amt,
   output logic       out_last,
   output logic [7:0] res_cnt
);

`ifdef SHIFT_SWEEP_EN
   localparam bit SweepEn = 1'b1;
`else
   localparam bit SweepEn = 1'b0;
`endif

   typedef enum logic [1:0] {StIdle, StDrive, StOut} state_e;

   state_e     state;
   logic [7:0] data_r;
   logic [2:0] amt_r;
   logic       sweep_r;

   // The shifter sees the latched operands directly, so they hold outside DRIVE.
   assign sh_in    = data_r;
   assign sh_amt   = amt_r;
   assign in_ready = (state == StIdle) && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         data_r    <= 8'd0;
         amt_r     <= 3'd0;
         sweep_r   <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= 8'd0;
         out_amt   <= 3'd0;
         out_last  <= 1'b0;
         res_cnt   <= 8'd0;
      end else begin
         case (state)
            StIdle: begin
               if (in_valid) begin
                  data_r  <= in_data;
                  amt_r   <= in_amt;
                  sweep_r <= in_sweep & SweepEn;
                  state   <= StDrive;
               end
            end
            StDrive: begin
               out_data  <= sh_q;
               out_amt   <= amt_r;
               out_last  <= !sweep_r || (amt_r == 3'd7);
               out_valid <= 1'b1;
               state     <= StOut;
            end
            StOut: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  res_cnt   <= res_cnt + 8'd1;
                  // out_last is set at amt 7, so the increment below never wraps.
                  if (!out_last) begin
                     amt_r <= amt_r + 3'd1;
                     state <= StDrive;
                  end else begin
                     state <= StIdle;
                  end
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_feeder.sv
// Directed bench for shift_feeder; the shift block is modelled as q = in << shift.
module tb_shift_feeder;

`ifdef SHIFT_SWEEP_EN
   localparam bit SweepOn = 1'b1;
`else
   localparam bit SweepOn = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic [2:0] in_amt;
   logic       in_sweep;
   logic [7:0] sh_in;
   logic [2:0] sh_amt;
   logic [7:0] sh_q;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [2:0] out_amt;
   logic       out_last;
   logic [7:0] res_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign sh_q = sh_in << sh_amt;

   shift_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_sweep  (in_sweep),
      .sh_in     (sh_in),
      .sh_amt    (sh_amt),
      .sh_q      (sh_q),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_amt   (out_amt),
      .out_last  (out_last),
      .res_cnt   (res_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance until out_valid is seen or the budget runs out; caller checks out_valid.
   task automatic wait_valid(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (out_valid) return;
         tick();
      end
   endtask

   int          n;
   int          exp_n;
   logic [7:0]  base_cnt;
   logic [7:0]  d;
   logic [2:0]  a;
   logic [7:0]  exp_q;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; in_amt = 3'd0; in_sweep = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_res_cnt", res_cnt, 0);
      check("rst_sh_in", sh_in, 0);
      check("rst_sh_amt", sh_amt, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_last", out_last, 0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", in_ready, 1);

      // 0x01 << 3, consumer always ready
      in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd3; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_drive_valid", out_valid, 0);
      check("t1_drive_in_ready", in_ready, 0);
      check("t1_sh_in", sh_in, 8'h01);
      check("t1_sh_amt", sh_amt, 3);
      check("t1_drive_res_cnt", res_cnt, 0);
      tick();
      check("t1_out_valid", out_valid, 1);
      check("t1_out_data", out_data, 8'h08);
      check("t1_out_amt", out_amt, 3);
      check("t1_out_last", out_last, 1);
      tick();
      check("t1_done_valid", out_valid, 0);
      check("t1_res_cnt", res_cnt, 1);
      check("t1_in_ready", in_ready, 1);

      // 0x81 << 1 with backpressure; stray in_valid must be ignored
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1;
      tick();
      in_data = 8'hff; in_amt = 3'd6;
      tick();
      check("t2_out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t2_hold_valid", out_valid, 1);
         check("t2_hold_data", out_data, 8'h02);
         check("t2_hold_amt", out_amt, 1);
         check("t2_hold_in_ready", in_ready, 0);
         check("t2_hold_sh_in", sh_in, 8'h81);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      check("t2_release_valid", out_valid, 0);
      check("t2_res_cnt", res_cnt, 2);
      tick();
      tick();
      check("t2_single_valid", out_valid, 0);
      check("t2_single_res_cnt", res_cnt, 2);

      // sweep 0x01 from amt 0
      base_cnt = res_cnt;
      exp_n = SweepOn ? 8 : 1;
      in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd0; in_sweep = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (out_valid) begin
            d = 8'h01 << n;
            check("t3_data", out_data, d);
            check("t3_amt", out_amt, n);
            check("t3_last", out_last, SweepOn ? (n == 7) : 1);
            n++;
         end
      end
      check("t3_count", n, exp_n);
      check("t3_res_cnt", res_cnt, base_cnt + exp_n[7:0]);

      // reset while a result is offered mid-sweep and out_ready is high
      in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd2; in_sweep = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (out_valid && out_amt == (SweepOn ? 3'd4 : 3'd2)) break;
         tick();
      end
      check("t4_mid_valid", out_valid, 1);
      check("t4_mid_amt", out_amt, SweepOn ? 4 : 2);
      rst = 1'b1;
      #1;
      check("t4_rst_in_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      check("t4_valid", out_valid, 0);
      check("t4_res_cnt", res_cnt, 0);
      check("t4_out_data", out_data, 0);
      check("t4_sh_amt", sh_amt, 0);
      check("t4_in_ready", in_ready, 1);
      in_valid = 1'b1; in_data = 8'h05; in_amt = 3'd2; in_sweep = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      wait_valid(10);
      check("t4_new_valid", out_valid, 1);
      check("t4_new_data", out_data, 8'h14);
      check("t4_new_last", out_last, 1);
      tick();
      check("t4_new_res_cnt", res_cnt, 1);

      // 256 back-to-back requests from a clean counter
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b1; in_sweep = 1'b0;
      in_data = 8'h5a; in_amt = 3'd0;
      for (int i = 0; i < 256; i++) begin
         tick();
         d = i[7:0] ^ 8'h5a;
         a = i[2:0];
         exp_q = d << a;
         in_data = (i[7:0] + 8'd1) ^ 8'h5a;
         in_amt = a + 3'd1;
         tick();
         if (i == 0 || i == 127 || i == 255) begin
            check("t5_valid", out_valid, 1);
            check("t5_data", out_data, exp_q);
         end
         tick();
         if (i == 254) check("t5_res_cnt_255", res_cnt, 255);
         if (i == 255) check("t5_res_cnt_wrap", res_cnt, 0);
      end
      in_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_feeder.md
SHIFT_FEEDER -- requirements
Module: shift_feeder

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_valid  input  1  request present.
REQ-004 SHALL have port: in_ready  output  1  request accepted this cycle when in_valid also high.
REQ-005 SHALL have port: in_data  input  8  operand word.
REQ-006 SHALL have port: in_amt  input  3  shift amount.
REQ-007 SHALL have port: in_sweep  input  1  request sweep from in_amt through 7; ignored without SHIFT_SWEEP_EN.
REQ-008 SHALL have ports sh_in (output, 8), sh_amt (output, 3) and sh_q (input, 8), wired to in, shift and q of the combinational shift block.
REQ-009 SHALL have port: out_valid  output  1  result present.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: out_data  output  8  registered shift result.
REQ-012 SHALL have port: out_amt  output  3  shift amount that produced out_data.
REQ-013 SHALL have port: out_last  output  1  final result of the current request.
REQ-014 SHALL have port: res_cnt  output  8  count of completed output handshakes, wraps 255->0.

Function
REQ-015 SHALL implement FSM states IDLE, DRIVE, OUT.
REQ-016 In IDLE, SHALL drive in_ready=1; in all other states, in_ready=0, so requests never overlap.
REQ-017 On IDLE with in_valid=1, SHALL latch in_data, in_amt and sweep flag (in_sweep AND macro) into internal registers and go to DRIVE.
REQ-018 In DRIVE, sh_in/sh_amt SHALL equal the latched registers; at the end of the cycle the block SHALL capture sh_q into out_data and amt into out_amt, then go to OUT.
REQ-019 sh_in/sh_amt SHALL hold their last latched values in IDLE and OUT; they SHALL be 0 after reset.
REQ-020 In OUT, out_valid SHALL be 1; out_data, out_amt and out_last SHALL stay stable until out_ready=1.
REQ-021 Latency: request accepted at edge N gives out_valid=1 from edge N+2; minimum of 3 cycles per non-sweep request, including the handshake cycle.
REQ-022 out_last SHALL be 1 when the sweep flag is 0 or amt=7.
REQ-023 On an OUT handshake, res_cnt SHALL increment; if out_last=0, amt SHALL increment and the FSM SHALL go to DRIVE; otherwise it SHALL go to IDLE.
REQ-024 Amount arithmetic SHALL be 3-bit; sweep SHALL terminate at 7 and never wrap to 0.
REQ-025 in_valid during DRIVE/OUT SHALL be ignored and SHALL leave latched registers unchanged.
REQ-026 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-027 rst SHALL take priority over every other input, including mid-sweep and mid-handshake.
REQ-028 On rst, SHALL set state=IDLE and all registers, out_valid, out_last, out_data, out_amt and res_cnt to 0.
REQ-029 While rst=1, in_ready SHALL read 0; in_ready SHALL be 1 on the first cycle after rst falls.

Configuration
REQ-030 Macro SHIFT_SWEEP_EN defined: in_sweep SHALL be honoured, giving 8-in_amt results per request.
REQ-031 Macro SHIFT_SWEEP_EN undefined: sweep flag SHALL be constant 0, and every request SHALL give exactly one result with out_last=1.

Verification
REQ-032 Bench SHALL cover: in_data=0x01, amt=3, out_ready=1 -> out_data=0x08, out_amt=3, out_last=1, out_valid exactly 2 cycles after acceptance; res_cnt=1.
REQ-033 Bench SHALL cover: in_data=0x81, amt=1, out_ready held 0 for 5 cycles -> out_data=0x02 held stable, in_ready=0 throughout; single handshake when released.
REQ-034 Bench SHALL cover (macro defined): in_data=0x01, amt=0, sweep=1, out_ready=1 -> 8 results 0x01,0x02,...,0x80; out_last only on amt=7; res_cnt=8.
REQ-035 Bench SHALL cover (macro undefined): same stimulus as REQ-034 -> single result 0x01 with out_last=1.
REQ-036 Bench SHALL cover: rst asserted while in OUT mid-sweep (amt=4) -> next cycle out_valid=0, res_cnt=0, state IDLE; a new request is accepted after rst.
REQ-037 Bench SHALL cover: 256 back-to-back single requests -> res_cnt wraps to 0.

Bench SHALL connect the team's shift block, with q = in << shift (logical).
